// File: rtl/sram_req_responder.sv
// sram_req_responder: valid/ready request front end for a 1-cycle SRAM macro.
// Ports: clock/reset_n, req_* in, rsp_* out via credit-guarded FIFO, sram_* to macro.
module sram_req_responder #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_en,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int PW   = $clog2(RSP_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = PW + 2;

  logic                   iss_v_q, iss_v_d;
  logic                   iss_we_q, iss_we_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic                   ret_v_q, ret_v_d;
  logic                   ret_we_q, ret_we_d;

  logic [DATA_WIDTH-1:0]  fifo_rdata_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_rdata_d [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]   fifo_wr_q, fifo_wr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;

  logic [CW-1:0]          used;
  logic                   req_fire;
  logic                   push;
  logic                   pop;

  // Every accepted request reserves a FIFO slot up front, so
  // the issue and return stages can never overflow the FIFO.
  always_comb begin
    used = CW'(cnt_q) + CW'(iss_v_q) + CW'(ret_v_q);
  end

  assign req_ready = reset_n & (used < CW'(RSP_DEPTH));
  assign req_fire  = req_valid & req_ready;
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = ret_v_q;

  assign sram_en    = iss_v_q;
  assign sram_we    = iss_we_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;

  assign rsp_write = rsp_valid & fifo_wr_q[rd_ptr_q];
  assign rsp_rdata = rsp_valid ? fifo_rdata_q[rd_ptr_q] : '0;

  always_comb begin
    iss_v_d  = req_fire;
    iss_we_d = req_fire & req_we;
    wmask_d  = wmask_q;
    addr_d   = addr_q;
    din_d    = din_q;
    if (req_fire) begin
      wmask_d = req_wmask;
      addr_d  = req_addr;
      din_d   = req_wdata;
    end

    ret_v_d  = iss_v_q;
    ret_we_d = iss_we_q;

    // Macro dout is valid while the return stage is occupied.
    fifo_rdata_d = fifo_rdata_q;
    fifo_wr_d    = fifo_wr_q;
    if (push) begin
      fifo_wr_d[wr_ptr_q]    = ret_we_q;
      fifo_rdata_d[wr_ptr_q] = ret_we_q ? '0 : sram_dout;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iss_v_q   <= 1'b0;
      iss_we_q  <= 1'b0;
      wmask_q   <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      ret_v_q   <= 1'b0;
      ret_we_q  <= 1'b0;
      fifo_wr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_rdata_q[i] <= '0;
      end
    end else begin
      iss_v_q      <= iss_v_d;
      iss_we_q     <= iss_we_d;
      wmask_q      <= wmask_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      ret_v_q      <= ret_v_d;
      ret_we_q     <= ret_we_d;
      fifo_wr_q    <= fifo_wr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      fifo_rdata_q <= fifo_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_req_responder.sv
// tb_sram_req_responder: randomized and directed bench for sram_req_responder.
// Holds a macro model plus an abstract memory/response-order reference model.
module tb_sram_req_responder;

  localparam int DW = 4;
  localparam int AW = 6;
  localparam int MW = 2;
  localparam int D  = 4;
  localparam int LW = DW / MW;

  typedef logic [DW:0] rsp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [MW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          sram_en;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  always #5 clock = ~clock;

  sram_req_responder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  logic [DW-1:0] dev_mem [1<<AW];
  logic [DW-1:0] dev_dout;
  bit            dev_init = 1'b0;

  assign sram_dout = dev_dout;

  always @(posedge clock) begin
    if (!dev_init) begin
      for (int i = 0; i < (1<<AW); i++) dev_mem[i] <= DW'(i*5+3);
      dev_init <= 1'b1;
    end else if (sram_en) begin
      if (sram_we) begin
        for (int l = 0; l < MW; l++)
          if (sram_wmask[l])
            dev_mem[sram_addr][l*LW +: LW] <= sram_din[l*LW +: LW];
      end else begin
        dev_dout <= dev_mem[sram_addr];
      end
    end
  end

  logic [DW-1:0] ref_mem [1<<AW];
  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ready_bad = 0;
  int   stall_bad = 0;
  int   outst = 0;
  logic prev_stall = 1'b0;
  rsp_t prev_rsp = '0;

  task automatic tick();
    #1;
    if (req_ready !== (reset_n && outst < D)) ready_bad++;
    if (prev_stall &&
        (rsp_valid !== 1'b1 || {rsp_write, rsp_rdata} !== prev_rsp))
      stall_bad++;
    prev_stall = rsp_valid && !rsp_ready;
    prev_rsp = {rsp_write, rsp_rdata};
    if (req_valid && req_ready) begin
      if (req_we) begin
        for (int l = 0; l < MW; l++)
          if (req_wmask[l])
            ref_mem[req_addr][l*LW +: LW] = req_wdata[l*LW +: LW];
        exp_q.push_back({1'b1, DW'(0)});
      end else begin
        exp_q.push_back({1'b0, ref_mem[req_addr]});
      end
      outst++;
    end
    if (rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_write, rsp_rdata});
      outst--;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_we = we;
    req_wmask = m;
    req_addr = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    if ({req_ready, rsp_valid, rsp_write, rsp_rdata, sram_en, sram_we,
         sram_wmask, sram_addr, sram_din} !== '0) begin
      $display("FAIL reset_outs: got %b want 0", {req_ready, rsp_valid,
               rsp_write, rsp_rdata, sram_en, sram_we, sram_wmask,
               sram_addr, sram_din});
      n_bad++;
    end
    n_cmp++;
    reset_n = 1'b1;
    #1;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b want 1", req_ready);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    issue(1'b1, 2'b11, 6'd0, 4'd13);
    if ({sram_en, sram_we, sram_wmask, sram_addr, sram_din} !==
        {1'b1, 1'b1, 2'b11, 6'd0, 4'd13}) begin
      $display("FAIL basic_issue: got %h", {sram_en, sram_we, sram_wmask,
               sram_addr, sram_din});
      n_bad++;
    end
    n_cmp++;
    tick();
    if ({sram_en, sram_we, sram_addr, sram_din, rsp_valid} !==
        {1'b0, 1'b0, 6'd0, 4'd13, 1'b0}) begin
      $display("FAIL basic_idle: got %h", {sram_en, sram_we, sram_addr,
               sram_din, rsp_valid});
      n_bad++;
    end
    n_cmp++;
    tick();
    if ({rsp_valid, rsp_write, rsp_rdata} !== {1'b1, 1'b1, 4'd0}) begin
      $display("FAIL basic_ack: got %b want 110000",
               {rsp_valid, rsp_write, rsp_rdata});
      n_bad++;
    end
    n_cmp++;
    tick();
    issue(1'b0, 2'b00, 6'd0, 4'd0);
    tick();
    tick();
    if ({rsp_valid, rsp_write, rsp_rdata} !== {1'b1, 1'b0, 4'd13}) begin
      $display("FAIL basic_read: got %b want 101101",
               {rsp_valid, rsp_write, rsp_rdata});
      n_bad++;
    end
    n_cmp++;
    drain();
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL basic_count: got %0d want %0d",
               got_q.size(), exp_q.size());
      n_bad++;
    end
    n_cmp++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_mask();
    rsp_ready = 1'b0;
    issue(1'b1, 2'b11, 6'd5, 4'd13);
    issue(1'b1, 2'b01, 6'd5, 4'd0);
    issue(1'b0, 2'b00, 6'd5, 4'd0);
    issue(1'b1, 2'b00, 6'd5, 4'd0);
    drain();
    issue(1'b0, 2'b00, 6'd5, 4'd0);
    drain();
    if (got_q.size() !== 5) begin
      $display("FAIL mask_count: got %0d want 5", got_q.size());
      n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL mask_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
        n_bad++;
      end
      n_cmp++;
    end
    if (got_q.size() == 5) begin
      if (got_q[2] !== {1'b0, 4'd12} || got_q[4] !== {1'b0, 4'd12}) begin
        $display("FAIL mask_value: got %h/%h want 0c/0c", got_q[2], got_q[4]);
        n_bad++;
      end
      n_cmp++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_credit();
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = AW'(10 + i);
      tick();
    end
    req_valid = 1'b0;
    if (exp_q.size() !== 4) begin
      $display("FAIL credit_accepted: got %0d want 4", exp_q.size());
      n_bad++;
    end
    n_cmp++;
    tick();
    tick();
    if (req_ready !== 1'b0) begin
      $display("FAIL credit_full: got %b want 0", req_ready);
      n_bad++;
    end
    n_cmp++;
    drain();
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL credit_count: got %0d want %0d",
               got_q.size(), exp_q.size());
      n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL credit_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
        n_bad++;
      end
      n_cmp++;
    end
    if (req_ready !== 1'b1) begin
      $display("FAIL credit_release: got %b want 1", req_ready);
      n_bad++;
    end
    n_cmp++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    issue(1'b1, 2'b11, 6'd63, 4'd9);
    if ({sram_en, sram_we} !== 2'b11) begin
      $display("FAIL b2b_en1: got %b want 11", {sram_en, sram_we});
      n_bad++;
    end
    n_cmp++;
    issue(1'b0, 2'b00, 6'd63, 4'd0);
    if ({sram_en, sram_we, sram_addr} !== {2'b10, 6'd63}) begin
      $display("FAIL b2b_en2: got %b want 10111111",
               {sram_en, sram_we, sram_addr});
      n_bad++;
    end
    n_cmp++;
    drain();
    if (got_q.size() !== 2 || got_q[1] !== {1'b0, 4'd9}) begin
      $display("FAIL b2b_read: got n=%0d last=%h want n=2 last=09",
               got_q.size(), got_q[got_q.size()-1]);
      n_bad++;
    end
    n_cmp++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_toggle();
    int k = 0;
    bit fresh = 1'b1;
    rsp_ready = 1'b0;
    for (int c = 0; c < 80 && k < 8; c++) begin
      int n0;
      if (fresh) begin
        req_we = 1'($urandom);
        req_wmask = MW'($urandom);
        req_addr = AW'($urandom_range(20, 23));
        req_wdata = DW'($urandom);
        fresh = 1'b0;
      end
      req_valid = 1'b1;
      rsp_ready = ~rsp_ready;
      n0 = exp_q.size();
      tick();
      if (exp_q.size() != n0) begin
        k++;
        fresh = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (k !== 8) begin
      $display("FAIL toggle_accept: got %0d want 8", k);
      n_bad++;
    end
    n_cmp++;
    drain();
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL toggle_count: got %0d want %0d",
               got_q.size(), exp_q.size());
      n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL toggle_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
        n_bad++;
      end
      n_cmp++;
    end
    if (stall_bad !== 0) begin
      $display("FAIL toggle_stable: got %0d unstable want 0", stall_bad);
      n_bad++;
    end
    n_cmp++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we = 1'($urandom);
      req_wmask = MW'($urandom);
      req_addr = ($urandom_range(0, 9) == 0) ? AW'(63) :
                 AW'($urandom_range(0, 7));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL rand_count: got %0d want %0d",
               got_q.size(), exp_q.size());
      n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL rand_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
        n_bad++;
      end
      n_cmp++;
    end
    if (ready_bad !== 0 || stall_bad !== 0) begin
      $display("FAIL rand_flow: got ready_err=%0d stall_err=%0d want 0/0",
               ready_bad, stall_bad);
      n_bad++;
    end
    n_cmp++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_flush();
    rsp_ready = 1'b1;
    issue(1'b0, 2'b00, 6'd1, 4'd0);
    issue(1'b0, 2'b00, 6'd2, 4'd0);
    reset_n = 1'b0;
    exp_q.delete();
    got_q.delete();
    outst = 0;
    prev_stall = 1'b0;
    #1;
    if ({req_ready, rsp_valid, sram_en} !== 3'b000) begin
      $display("FAIL flush_in_reset: got %b want 000",
               {req_ready, rsp_valid, sram_en});
      n_bad++;
    end
    n_cmp++;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    if (req_ready !== 1'b1) begin
      $display("FAIL flush_ready: got %b want 1", req_ready);
      n_bad++;
    end
    n_cmp++;
    repeat (6) tick();
    if (got_q.size() !== 0) begin
      $display("FAIL flush_no_rsp: got %0d responses want 0", got_q.size());
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = DW'(i*5+3);
    @(negedge clock);
    #1;
    test_reset();
    test_basic();
    test_mask();
    test_credit();
    test_back_to_back();
    test_toggle();
    test_random();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
